cache_set: RTL and testbench
============================

CACHE_SET -- requirements
Module: cache_set

Interface
REQ-001 The block SHALL have parameter `cache_entry`, default 6, giving log2 of the line count (64 lines).
REQ-002 Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port `entry`, input, `cache_entry` bits: line index.
REQ-005 Port `o_tag`, input, 28-`cache_entry` bits: tag to compare and store.
REQ-006 Port `writedata`, input, 128 bits: line data; word w occupies bits [32w+31:32w].
REQ-007 Port `byte_en`, input, 4 bits: byte mask, applied inside every enabled word.
REQ-008 Port `write`, input, 1 bit: write strobe.
REQ-009 Port `word_en`, input, 4 bits: word mask.
REQ-010 Port `read_miss`, input, 1 bit: the current write is a fill for a read miss.
REQ-011 Port `readdata`, output, 128 bits: stored line at `entry`.
REQ-012 Port `wb_addr`, output, 28 bits: line address of the stored line, {stored tag, `entry`}.
REQ-013 Port `hit`, output, 1 bit: the line is valid and its stored tag equals `o_tag`.
REQ-014 Port `miss`, output, 1 bit: the inverse of `hit`.
REQ-015 Port `valid`, output, 1 bit: valid bit of the line at `entry`.
REQ-016 Port `modify`, output, 1 bit: the line at `entry` is valid and dirty.

Function
REQ-017 The block SHALL hold one way of a 4-way cache: 2^`cache_entry` lines, each with 128-bit data, a tag, a valid bit and a dirty bit.
REQ-018 All outputs SHALL be combinational from `entry`, `o_tag` and the stored state (asynchronous read) and SHALL reflect a write from the next cycle.
REQ-019 When `write`=1 at a clock edge, the block SHALL write byte b of word w of line `entry` with `writedata`[32w+8b+7:32w+8b] for every w with `word_en`[w]=1 and b with `byte_en`[b]=1; all other bytes SHALL be unchanged.
REQ-020 The same write SHALL set tag[`entry`] to `o_tag` and valid[`entry`] to 1.
REQ-021 The same write SHALL set dirty[`entry`] to 0 when `read_miss`=1 and to 1 when `read_miss`=0.
REQ-022 When `write`=0, the block SHALL leave all stored state unchanged.
REQ-023 An all-zero `word_en` or `byte_en` with `write`=1 SHALL still update tag, valid and dirty.

Reset
REQ-024 When `rst`=1 at a clock edge, all valid and dirty bits SHALL clear to 0; then `hit`=0, `miss`=1, `valid`=0 and `modify`=0 for every entry.
REQ-025 Reset SHALL NOT clear data or tags, and SHALL take priority over a simultaneous `write`.

Structure
REQ-026 A shared package SHALL hold the line width (128), word count (4), address width (28) and the derived tag width.
REQ-027 The sub-module `simple_ram` SHALL be a generic memory with parameters `width` (default 8) and `widthad` (default 6) and ports in this order: `clk`, `wraddress`, `wren`, `data`, `rdaddress`, `q`.
REQ-028 `simple_ram` SHALL write on the rising edge when `wren`=1 and read combinationally.
REQ-029 `simple_ram` SHALL keep its storage in an array named `mem` so parents can initialise it hierarchically.
REQ-030 `cache_set` SHALL use `simple_ram` for its tag store; the data store with byte masking SHALL be a local register array.

Verification
REQ-031 Scenario: reset, then any `entry` -> `valid`=0, `hit`=0, `miss`=1, `modify`=0.
REQ-032 Scenario: fill `entry`=5, `o_tag`=0x12345, `word_en`=`byte_en`=0xF, `read_miss`=1, data 0x44..33..22..11 -> next cycle `hit`=1, `modify`=0, `readdata` equals the written data, `wb_addr`=0x48D145.
REQ-033 Scenario: write to `entry`=5, `word_en`=0010, `byte_en`=0001, `writedata`=4x0xAABBCCDD, `read_miss`=0 -> only `readdata`[39:32]=0xDD changes; `modify`=1.
REQ-034 Scenario: `entry`=5 with `o_tag`=0x12346 -> `hit`=0, `miss`=1, `valid`=1, `wb_addr` still reports tag 0x12345.
REQ-035 Scenario: `rst` and `write` asserted together -> `valid`=0 afterwards.
REQ-036 Scenario: `simple_ram` write 0xE4 at address 3, then read address 3 -> `q`=0xE4 in the same cycle the address is applied.

Source files
------------

// File: rtl/cache_set_pkg.sv
// Shared geometry for one cache way: line, word and address widths.
package cache_set_pkg;

   localparam int LINE_W = 128;
   localparam int WORDS  = 4;
   localparam int WORD_W = LINE_W / WORDS;
   localparam int BYTES  = WORD_W / 8;
   localparam int ADDR_W = 28;

   function automatic int tag_w(input int index_w);
      return ADDR_W - index_w;
   endfunction

endpackage

// File: rtl/simple_ram.sv
// Generic register-file memory: synchronous write, combinational read.
module simple_ram #(
   parameter int width   = 8,
   parameter int widthad = 6
) (
   input  logic               clk,
   input  logic [widthad-1:0] wraddress,
   input  logic               wren,
   input  logic [width-1:0]   data,
   input  logic [widthad-1:0] rdaddress,
   output logic [width-1:0]   q
);

   logic [width-1:0] mem [0:(1<<widthad)-1];

   always_ff @(posedge clk) begin
      if (wren) begin
         mem[wraddress] <= data;
      end
   end

   assign q = mem[rdaddress];

endmodule

// File: rtl/cache_set.sv
// One way of a 4-way cache: byte-masked data lines, tag store, valid/dirty.
module cache_set
   import cache_set_pkg::*;
#(
   parameter int cache_entry = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [cache_entry-1:0]        entry,
   input  logic [tag_w(cache_entry)-1:0] o_tag,
   input  logic [LINE_W-1:0]             writedata,
   input  logic [BYTES-1:0]              byte_en,
   input  logic                          write,
   input  logic [WORDS-1:0]              word_en,
   input  logic                          read_miss,
   output logic [LINE_W-1:0]             readdata,
   output logic [ADDR_W-1:0]             wb_addr,
   output logic                          hit,
   output logic                          miss,
   output logic                          valid,
   output logic                          modify
);

   localparam int LINES = 1 << cache_entry;
   localparam int TAG_W = tag_w(cache_entry);

   logic [LINE_W-1:0] r_data [0:LINES-1];
   logic [LINES-1:0]  r_valid;
   logic [LINES-1:0]  r_dirty;
   logic [TAG_W-1:0]  w_tag;
   logic              w_wr;

   // Reset wins over a coincident write, including the tag store.
   assign w_wr = write & ~rst;

   simple_ram #(
      .width   (TAG_W),
      .widthad (cache_entry)
   ) u_tag (
      .clk       (clk),
      .wraddress (entry),
      .wren      (w_wr),
      .data      (o_tag),
      .rdaddress (entry),
      .q         (w_tag)
   );

   always_ff @(posedge clk) begin
      if (w_wr) begin
         for (int w = 0; w < WORDS; w++) begin
            for (int b = 0; b < BYTES; b++) begin
               if (word_en[w] && byte_en[b]) begin
                  r_data[entry][WORD_W*w+8*b +: 8] <=
                     writedata[WORD_W*w+8*b +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (write) begin
         r_valid[entry] <= 1'b1;
         r_dirty[entry] <= ~read_miss;
      end
   end

   assign readdata = r_data[entry];
   assign wb_addr  = {w_tag, entry};
   assign valid    = r_valid[entry];
   assign modify   = r_valid[entry] & r_dirty[entry];
   assign hit      = r_valid[entry] && (w_tag == o_tag);
   assign miss     = ~hit;

endmodule

// File: tb/tb_cache_set.sv
// Scoreboard bench for cache_set and its simple_ram tag store.
module tb_cache_set;

   localparam int CE = 6;
   localparam int TW = 28 - CE;

   typedef enum int {
      S_HIT, S_MISS, S_VALID, S_MOD, S_DATA, S_WB, S_Q
   } sel_e;

   typedef struct {
      string        name;
      sel_e         sel;
      logic [127:0] exp;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [CE-1:0] entry;
   logic [TW-1:0] o_tag;
   logic [127:0]  writedata;
   logic [3:0]    byte_en;
   logic          write;
   logic [3:0]    word_en;
   logic          read_miss;
   logic [127:0]  readdata;
   logic [27:0]   wb_addr;
   logic          hit, miss, valid, modify;

   logic [5:0]    r_wa, r_ra;
   logic          r_wren;
   logic [7:0]    r_d, r_q;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   bit   stim_done = 0;

   always #5 clk = ~clk;

   cache_set #(.cache_entry(CE)) dut (
      .clk(clk), .rst(rst), .entry(entry), .o_tag(o_tag),
      .writedata(writedata), .byte_en(byte_en), .write(write),
      .word_en(word_en), .read_miss(read_miss), .readdata(readdata),
      .wb_addr(wb_addr), .hit(hit), .miss(miss), .valid(valid),
      .modify(modify)
   );

   simple_ram #(.width(8), .widthad(6)) u_ram (
      .clk(clk), .wraddress(r_wa), .wren(r_wren), .data(r_d),
      .rdaddress(r_ra), .q(r_q)
   );

   task automatic expect_v(input string n, input sel_e s,
                           input logic [127:0] v);
      exp_t e;
      e.name = n;
      e.sel  = s;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [CE-1:0] e, input logic [TW-1:0] t,
                     input logic [127:0] d, input logic [3:0] we,
                     input logic [3:0] be, input logic rm);
      entry = e; o_tag = t; writedata = d;
      word_en = we; byte_en = be; read_miss = rm; write = 1'b1;
      step();
      write = 1'b0;
   endtask

   // Monitor: outputs are combinational, so compare on the falling edge.
   initial begin
      exp_t e;
      logic [127:0] act;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
               S_HIT:   act = {127'd0, hit};
               S_MISS:  act = {127'd0, miss};
               S_VALID: act = {127'd0, valid};
               S_MOD:   act = {127'd0, modify};
               S_DATA:  act = readdata;
               S_WB:    act = {100'd0, wb_addr};
               default: act = {120'd0, r_q};
            endcase
            total++;
            if (act !== e.exp) begin
               bad++;
               $display("FAIL %s: got %h want %h", e.name, act, e.exp);
            end
         end
      end
   end

   localparam logic [127:0] FILL =
      {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
   localparam logic [127:0] PART =
      {32'h44444444, 32'h33333333, 32'h222222DD, 32'h11111111};

   initial begin
      int n;
      rst = 1'b1; write = 1'b0; entry = '0; o_tag = '0;
      writedata = '0; byte_en = '0; word_en = '0; read_miss = 1'b0;
      r_wa = '0; r_ra = '0; r_wren = 1'b0; r_d = '0;
      step();
      step();
      rst = 1'b0;

      // reset state on a few entries
      foreach (sb[i]) ;
      for (int i = 0; i < 3; i++) begin
         entry = (i == 0) ? 6'd0 : (i == 1) ? 6'd5 : 6'd63;
         expect_v("rst_valid", S_VALID, 128'd0);
         expect_v("rst_hit", S_HIT, 128'd0);
         expect_v("rst_miss", S_MISS, 128'd1);
         expect_v("rst_mod", S_MOD, 128'd0);
         step();
      end

      // read-miss fill
      wr(6'd5, 22'h12345, FILL, 4'hF, 4'hF, 1'b1);
      expect_v("fill_hit", S_HIT, 128'd1);
      expect_v("fill_mod", S_MOD, 128'd0);
      expect_v("fill_data", S_DATA, FILL);
      expect_v("fill_wb", S_WB, 128'h48D145);
      step();

      // single-byte store hit
      wr(6'd5, 22'h12345, {4{32'hAABBCCDD}}, 4'b0010, 4'b0001, 1'b0);
      expect_v("part_data", S_DATA, PART);
      expect_v("part_mod", S_MOD, 128'd1);
      expect_v("part_hit", S_HIT, 128'd1);
      step();

      // tag mismatch
      o_tag = 22'h12346;
      expect_v("tm_hit", S_HIT, 128'd0);
      expect_v("tm_miss", S_MISS, 128'd1);
      expect_v("tm_valid", S_VALID, 128'd1);
      expect_v("tm_wb", S_WB, 128'h48D145);
      step();

      // write=0 must not disturb state
      o_tag = 22'h00001; writedata = '1; word_en = 4'hF;
      byte_en = 4'hF; read_miss = 1'b1;
      step();
      o_tag = 22'h12345;
      expect_v("nowr_data", S_DATA, PART);
      expect_v("nowr_hit", S_HIT, 128'd1);
      expect_v("nowr_mod", S_MOD, 128'd1);
      step();

      // empty masks still update tag/valid/dirty
      wr(6'd7, 22'h00003, '1, 4'h0, 4'hF, 1'b0);
      expect_v("zwe_valid", S_VALID, 128'd1);
      expect_v("zwe_hit", S_HIT, 128'd1);
      expect_v("zwe_mod", S_MOD, 128'd1);
      expect_v("zwe_wb", S_WB, {100'd0, 22'h00003, 6'd7});
      step();
      wr(6'd7, 22'h3FFFFF, '1, 4'hF, 4'h0, 1'b1);
      expect_v("zbe_hit", S_HIT, 128'd1);
      expect_v("zbe_mod", S_MOD, 128'd0);
      expect_v("zbe_wb", S_WB, {100'd0, 22'h3FFFFF, 6'd7});
      step();

      // entry 5 is independent of entry 7
      entry = 6'd5; o_tag = 22'h12345;
      expect_v("iso_data", S_DATA, PART);
      step();

      // reset with simultaneous write
      rst = 1'b1;
      wr(6'd10, 22'h00ABC, FILL, 4'hF, 4'hF, 1'b0);
      rst = 1'b0;
      expect_v("rw_valid", S_VALID, 128'd0);
      expect_v("rw_hit", S_HIT, 128'd0);
      expect_v("rw_mod", S_MOD, 128'd0);
      step();

      // reset keeps data and tag of entry 5
      entry = 6'd5; o_tag = 22'h12345;
      expect_v("kept_data", S_DATA, PART);
      expect_v("kept_wb", S_WB, 128'h48D145);
      expect_v("kept_valid", S_VALID, 128'd0);
      expect_v("kept_miss", S_MISS, 128'd1);
      step();

      // standalone simple_ram
      r_wa = 6'd4; r_d = 8'h5A; r_wren = 1'b1;
      step();
      r_wa = 6'd3; r_d = 8'hE4;
      step();
      r_wren = 1'b0; r_ra = 6'd3;
      expect_v("ram_q3", S_Q, 128'hE4);
      step();
      r_ra = 6'd4;
      expect_v("ram_q4", S_Q, 128'h5A);
      step();

      n = 0;
      while (sb.size() > 0 && n < 10) begin
         step();
         n++;
      end
      if (sb.size() > 0) begin
         bad++;
         total++;
         $display("FAIL drain: got %0d left want 0", sb.size());
      end
      stim_done = 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
